// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher (NR = 10/12/14), one inverse round per cycle on a shared datapath.
// Define AES_INV_SPLIT_ROUND_EN to split each round into an S-box cycle and a key/mix cycle.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_in,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out,
  output logic         busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX = 4'(NR);

  // Byte i of a 128-bit word sits at bits [127-8i -: 8] (byte 0 most significant).
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row rw of output column c comes from column (c - rw) mod 4 of the input.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        o[127-8*(4*c+rw) -: 8] = INV_SBOX[s[127-8*(4*((c-rw+4)%4)+rw) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a  [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i]  = s[127-8*(4*c+i) -: 8];
        x2[i] = xt(a[i]);
        x4[i] = xt(x2[i]);
        x8[i] = xt(x4[i]);
        m9[i] = x8[i] ^ a[i];
        mb[i] = x8[i] ^ x2[i] ^ a[i];
        md[i] = x8[i] ^ x4[i] ^ a[i];
        me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      for (int i = 0; i < 4; i++) begin
        o[127-8*(4*c+i) -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      end
    end
    return o;
  endfunction

  state_t       state;
  logic [3:0]   r;
  logic [127:0] s_q;
  logic [127:0] inv_sb;
  logic [127:0] key_mix;
  logic         step_last;

  assign inv_sb   = inv_shift_sub(s_q);
  assign text_out = s_q;

`ifdef AES_INV_SPLIT_ROUND_EN
  logic         phase;
  logic [127:0] p_q;

  // First half of each step latches the S-box output; the second half adds the key.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p_q <= '0;
    end else if (!phase) begin
      p_q <= inv_sb;
    end
  end

  assign step_last = phase;
  assign key_mix   = p_q ^ round_key;
`else
  assign step_last = 1'b1;
  assign key_mix   = inv_sb ^ round_key;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      r         <= '0;
      s_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      key_idx   <= NR_IDX;
`ifdef AES_INV_SPLIT_ROUND_EN
      phase     <= 1'b0;
`endif
    end else begin
`ifdef AES_INV_SPLIT_ROUND_EN
      if (state == ROUND || state == FINAL) phase <= ~phase;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_q      <= text_in ^ round_key;
            r        <= NR_IDX - 4'd1;
            key_idx  <= NR_IDX - 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          if (step_last) begin
            s_q <= inv_mix_columns(key_mix);
            if (r == 4'd1) begin
              key_idx <= 4'd0;
              state   <= FINAL;
            end else begin
              r       <= r - 4'd1;
              key_idx <= r - 4'd1;
            end
          end
        end
        FINAL: begin
          if (step_last) begin
            s_q       <= key_mix;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result stays parked in s_q until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            key_idx   <= NR_IDX;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative, parametrised AES inverse-cipher engine. It decrypts one 128-bit block per transaction by running all `NR` inverse rounds on a single round datapath, one round per cycle. Round keys come from an external key-schedule store through a round-key request port. The block replaces chained fixed per-round instances in the decrypt path and adds valid/ready flow control, AES-192/256 support and output backpressure.

## Interface
- `NR`, default 10: number of rounds; legal values 10, 12, 14 (AES-128/192/256); any other value is a elaboration error.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 1: ciphertext on `text_in` is valid.
- `in_ready` output 1: engine can accept a block (high only in IDLE).
- `text_in` input [0:127]: ciphertext; bits 0:7 = byte 0, FIPS-197 column-major order.
- `key_idx` output 4: index of the round key required this cycle.
- `round_key` input [0:127]: round key `key_idx`, valid combinationally in the same cycle.
- `out_valid` output 1: plaintext on `text_out` is valid.
- `out_ready` input 1: consumer accepts `text_out`.
- `text_out` output [0:127]: plaintext, same byte order as `text_in`.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE; 4-bit round counter `r`; 128-bit state register `S`.
- IDLE: `key_idx`=NR. On `in_valid`: `S` <= `text_in` ^ `round_key`, `r` <= NR-1, go to ROUND.
- ROUND: `key_idx`=`r`. `S` <= InvMixColumns(InvSubBytes(InvShiftRows(`S`)) ^ `round_key`). When `r`==1, go to FINAL; otherwise `r` <= `r`-1.
- FINAL: `key_idx`=0. `S` <= InvSubBytes(InvShiftRows(`S`)) ^ `round_key`. Go to DONE.
- DONE: `key_idx`=0, `out_valid`=1, `text_out`=`S`. On `out_ready`, go to IDLE. `S` is held stable until that handshake.
- `text_out` is driven from `S` at all times; it is only meaningful while `out_valid` is high.
- `in_valid` outside IDLE is ignored; no internal queueing.
- InvMixColumns is applied independently to each 32-bit column (bytes 4c..4c+3). GF(2^8) reduction polynomial is 0x11B.
- Reset mid-operation aborts the block in flight. No partial result is ever presented.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `key_idx`=NR, `text_out`=0 (`S` cleared), `r`=0.
- Accept in cycle 0. ROUND occupies cycles 1..NR-1, FINAL occupies cycle NR, and `out_valid` rises in cycle NR+1. Latency = NR+1 cycles from accept.
- With `out_ready` tied high, the next accept can happen in cycle NR+2. Minimum initiation interval = NR+2 cycles.
- `out_valid` held low by backpressure is not possible: `out_valid` stays high and `text_out` is constant until `out_ready`.
- `key_idx` is a decode of state and `r` only; it never depends on `in_valid` or `out_ready`.

## Configuration
- `AES_INV_SPLIT_ROUND_EN` defined: each ROUND and FINAL step takes two cycles. In the first cycle a pipeline register captures InvSubBytes(InvShiftRows(`S`)). In the second cycle the AddRoundKey (and InvMixColumns, for ROUND) completes. `key_idx` is held constant across both cycles. Latency = 2·NR+1 and interval = 2·NR+2. Reset and handshake rules are unchanged.
- `AES_INV_SPLIT_ROUND_EN` undefined: single-cycle rounds as specified above.

## Test plan
- NR=10, FIPS-197 C.1: key 000102…0f, `text_in`=69c4e0d86a7b0430d8cdb78070b4c55a -> `text_out`=00112233445566778899aabbccddeeff with `out_valid` exactly 11 cycles after accept; `key_idx` sequence 10,9,…,1,0.
- NR=14, FIPS-197 C.3: key 000102…1f, `text_in`=8ea2b7ca516745bfeafc49904b496089 -> `text_out`=00112233445566778899aabbccddeeff, 15 cycles after accept. Also run NR=12 with the C.2 vector (dda97ca4864cdfe06eaf70a0ec0d7191), 13 cycles.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` -> `out_valid`=1 and `text_out` stable throughout, `in_ready`=0. Release -> IDLE next cycle and `in_ready`=1.
- Pulse `in_valid` with a different block during ROUND -> the pulse is ignored and the first block's result is unaffected. Two back-to-back blocks with `out_ready`=1 -> accepts exactly 12 cycles apart (NR=10).
- Assert `Reset` in cycle 5 of a decrypt -> outputs take reset values asynchronously, with no `out_valid`. The next block after release decrypts correctly.
- With `AES_INV_SPLIT_ROUND_EN`: repeat the C.1 vector -> same plaintext, `out_valid` 21 cycles after accept, each `key_idx` value held 2 cycles.
